// File: rtl/bank_isu_arb.sv
// rtl/bank_isu_arb.sv - four-channel round-robin request arbiter feeding the bank issue queue
//
// Each channel owns a 1-entry holding register. One holding register per cycle
// is granted round-robin into a registered output stage, tagged with its
// channel index.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   ch_valid_i / ch_allowIn_o    per-channel request handshake
//   ch_*_i                       per-channel payload fields, channel k at [W*k +: W]
//   arb_hold_i                   freeze grants (holding registers still fill)
//   out_valid_o / out_allowIn_i  handshake toward the issue queue
//   out_*_o                      granted payload and out_ch_id_o channel tag
//   busy_o                       any holding register or the output stage occupied
module bank_isu_arb #(
  parameter int NUM_CH = 4,
  parameter int PLD_W  = 24
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_CH-1:0]     ch_valid_i,
  output logic [NUM_CH-1:0]     ch_allowIn_o,
  input  logic [3*NUM_CH-1:0]   ch_rob_id_i,
  input  logic [2*NUM_CH-1:0]   ch_opcode_i,
  input  logic [7*NUM_CH-1:0]   ch_set_way_offset_i,
  input  logic [8*NUM_CH-1:0]   ch_wbuffer_id_i,
  input  logic [4*NUM_CH-1:0]   ch_cacheline_state_i,
  input  logic                  arb_hold_i,
  output logic                  out_valid_o,
  input  logic                  out_allowIn_i,
  output logic [2:0]            out_rob_id_o,
  output logic [1:0]            out_ch_id_o,
  output logic [1:0]            out_opcode_o,
  output logic [6:0]            out_set_way_offset_o,
  output logic [7:0]            out_wbuffer_id_o,
  output logic [3:0]            out_cacheline_state_o,
  output logic                  busy_o
);

  // Payload packing: {rob_id, opcode, set_way_offset, wbuffer_id, cacheline_state}
  logic [PLD_W-1:0]  ch_pld [NUM_CH];
  logic [PLD_W-1:0]  hold_pld_q [NUM_CH];
  logic [NUM_CH-1:0] hold_valid_q, hold_valid_d;
  logic [NUM_CH-1:0] accept;
  logic [NUM_CH-1:0] grant;
  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic [1:0]        gnt_idx;
  logic [1:0]        cand;
  logic              gnt_fire;
  logic              gnt_en;
  logic              stage_rdy;
  logic              out_valid_q;
  logic [1:0]        out_ch_q;
  logic [PLD_W-1:0]  out_pld_q;

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      ch_pld[k] = {ch_rob_id_i[3*k +: 3], ch_opcode_i[2*k +: 2],
                   ch_set_way_offset_i[7*k +: 7], ch_wbuffer_id_i[8*k +: 8],
                   ch_cacheline_state_i[4*k +: 4]};
    end
  end

  assign stage_rdy = ~out_valid_q | out_allowIn_i;
  assign gnt_en    = stage_rdy & ~arb_hold_i & (|hold_valid_q);

  // Search starts at rr_ptr and wraps; the first occupied holding register wins.
  always_comb begin
    gnt_fire = 1'b0;
    gnt_idx  = '0;
    cand     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = rr_ptr_q + 2'(i);
      if (gnt_en && !gnt_fire && hold_valid_q[cand]) begin
        gnt_fire = 1'b1;
        gnt_idx  = cand;
      end
    end
  end

  assign grant = gnt_fire ? ({{(NUM_CH-1){1'b0}}, 1'b1} << gnt_idx) : '0;

  // A draining entry may be refilled in the same cycle.
  assign ch_allowIn_o = ~hold_valid_q | grant;
  assign accept       = ch_valid_i & ch_allowIn_o;
  assign hold_valid_d = accept | (hold_valid_q & ~grant);
  assign rr_ptr_d     = gnt_fire ? gnt_idx + 2'd1 : rr_ptr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_valid_q <= '0;
      rr_ptr_q     <= '0;
      out_valid_q  <= 1'b0;
      out_ch_q     <= '0;
      out_pld_q    <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        hold_pld_q[k] <= '0;
      end
    end else begin
      hold_valid_q <= hold_valid_d;
      rr_ptr_q     <= rr_ptr_d;
      for (int k = 0; k < NUM_CH; k++) begin
        if (accept[k]) begin
          hold_pld_q[k] <= ch_pld[k];
        end
      end
      if (gnt_fire) begin
        out_valid_q <= 1'b1;
        out_ch_q    <= gnt_idx;
        out_pld_q   <= hold_pld_q[gnt_idx];
      end else if (out_allowIn_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid_o           = out_valid_q;
  assign out_ch_id_o           = out_ch_q;
  assign out_rob_id_o          = out_pld_q[23:21];
  assign out_opcode_o          = out_pld_q[20:19];
  assign out_set_way_offset_o  = out_pld_q[18:12];
  assign out_wbuffer_id_o      = out_pld_q[11:4];
  assign out_cacheline_state_o = out_pld_q[3:0];
  assign busy_o                = (|hold_valid_q) | out_valid_q;

endmodule

// File: tb/tb_bank_isu_arb.sv
// tb/tb_bank_isu_arb.sv - scoreboard bench for bank_isu_arb
module tb_bank_isu_arb;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [3:0]  ch_valid_i = '0;
  logic [3:0]  ch_allowIn_o;
  logic [11:0] ch_rob_id_i = '0;
  logic [7:0]  ch_opcode_i = '0;
  logic [27:0] ch_set_way_offset_i = '0;
  logic [31:0] ch_wbuffer_id_i = '0;
  logic [15:0] ch_cacheline_state_i = '0;
  logic        arb_hold_i = 1'b0;
  logic        out_valid_o;
  logic        out_allowIn_i = 1'b0;
  logic [2:0]  out_rob_id_o;
  logic [1:0]  out_ch_id_o;
  logic [1:0]  out_opcode_o;
  logic [6:0]  out_set_way_offset_o;
  logic [7:0]  out_wbuffer_id_o;
  logic [3:0]  out_cacheline_state_o;
  logic        busy_o;

  int total = 0;
  int bad   = 0;
  logic [25:0] exp_q[$];

  bank_isu_arb dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ch_valid_i(ch_valid_i), .ch_allowIn_o(ch_allowIn_o),
    .ch_rob_id_i(ch_rob_id_i), .ch_opcode_i(ch_opcode_i),
    .ch_set_way_offset_i(ch_set_way_offset_i), .ch_wbuffer_id_i(ch_wbuffer_id_i),
    .ch_cacheline_state_i(ch_cacheline_state_i), .arb_hold_i(arb_hold_i),
    .out_valid_o(out_valid_o), .out_allowIn_i(out_allowIn_i),
    .out_rob_id_o(out_rob_id_o), .out_ch_id_o(out_ch_id_o),
    .out_opcode_o(out_opcode_o), .out_set_way_offset_o(out_set_way_offset_o),
    .out_wbuffer_id_o(out_wbuffer_id_o), .out_cacheline_state_o(out_cacheline_state_o),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  // Distinct payload per (channel, generation)
  function automatic logic [23:0] mkp(input int ch, input int g);
    return {3'(ch + g), 2'(g), 7'(16 * ch + g), 8'(8'h30 + 8 * ch + g), 4'(ch + 3 * g)};
  endfunction

  task automatic set_ch(input int k, input logic [23:0] p);
    ch_rob_id_i[3*k +: 3]          = p[23:21];
    ch_opcode_i[2*k +: 2]          = p[20:19];
    ch_set_way_offset_i[7*k +: 7]  = p[18:12];
    ch_wbuffer_id_i[8*k +: 8]      = p[11:4];
    ch_cacheline_state_i[4*k +: 4] = p[3:0];
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input int ch, input logic [23:0] p);
    exp_q.push_back({2'(ch), p});
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) step();
    step();
    chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [25:0] got_out();
    return {out_ch_id_o, out_rob_id_o, out_opcode_o, out_set_way_offset_o,
            out_wbuffer_id_o, out_cacheline_state_o};
  endfunction

  // Monitor: every output handshake pops and compares one expected entry.
  always @(negedge clk_i) begin
    if (!rst_i && out_valid_o && out_allowIn_i) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected got=%h exp=none", got_out());
      end else begin
        chk("sb_out", 32'(got_out()), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic do_reset();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
  endtask

  logic [23:0] p1;

  initial begin
    // Reset state
    step();
    chk("rst_out_valid", 32'(out_valid_o), 32'd0);
    chk("rst_allowin", 32'(ch_allowIn_o), 32'hF);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_payload", 32'(got_out()), 32'd0);

    // Test 1: single request on ch2
    do_reset();
    p1 = {3'd5, 2'd1, 7'h2A, 8'h3C, 4'h9};
    out_allowIn_i = 1'b1;
    set_ch(2, p1);
    ch_valid_i = 4'b0100;
    push(2, p1);
    step();
    ch_valid_i = '0;
    chk("t1_not_yet_valid", 32'(out_valid_o), 32'd0);
    chk("t1_busy_hold", 32'(busy_o), 32'd1);
    chk("t1_allowin", 32'(ch_allowIn_o), 32'hF);
    step();
    chk("t1_valid", 32'(out_valid_o), 32'd1);
    chk("t1_ch_id", 32'(out_ch_id_o), 32'd2);
    step();
    chk("t1_done_valid", 32'(out_valid_o), 32'd0);
    chk("t1_busy_idle", 32'(busy_o), 32'd0);
    drain("t1");

    // Test 2: all channels continuously valid, refilled each grant
    do_reset();
    for (int k = 0; k < 4; k++) set_ch(k, mkp(k, 0));
    ch_valid_i = 4'hF;
    for (int n = 0; n < 10; n++) push(n % 4, mkp(n % 4, n / 4));
    step();
    for (int i = 0; i <= 10; i++) begin
      if (i >= 1) chk("t2_out_valid", 32'(out_valid_o), 32'd1);
      if (i <= 6) chk("t2_allowin", 32'(ch_allowIn_o), 32'(4'b0001 << (i % 4)));
      if (i < 6) set_ch(i % 4, mkp(i % 4, i / 4 + 1));
      if (i == 6) ch_valid_i = '0;
      step();
    end
    drain("t2");

    // Test 3: rr_ptr=2, ch0 and ch3 requesting
    set_ch(0, mkp(0, 3));
    set_ch(3, mkp(3, 3));
    ch_valid_i = 4'b1001;
    push(3, mkp(3, 3));
    push(0, mkp(0, 3));
    step();
    ch_valid_i = '0;
    step();
    chk("t3_first_ch", 32'(out_ch_id_o), 32'd3);
    drain("t3");

    // Test 4: backpressure with rr_ptr=1
    out_allowIn_i = 1'b0;
    for (int k = 0; k < 4; k++) set_ch(k, mkp(k, 4));
    ch_valid_i = 4'hF;
    push(1, mkp(1, 4));
    push(2, mkp(2, 4));
    push(3, mkp(3, 4));
    push(0, mkp(0, 4));
    push(1, mkp(1, 5));
    step();
    chk("t4_allowin_e0", 32'(ch_allowIn_o), 32'b0010);
    set_ch(1, mkp(1, 5));
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_stall_valid", 32'(out_valid_o), 32'd1);
      chk("t4_stall_payload", 32'(got_out()), 32'({2'd1, mkp(1, 4)}));
      chk("t4_stall_allowin", 32'(ch_allowIn_o), 32'd0);
    end
    ch_valid_i = '0;
    out_allowIn_i = 1'b1;
    drain("t4");

    // Test 5: arb_hold with ch0 pending, output drained
    arb_hold_i = 1'b1;
    set_ch(0, mkp(0, 7));
    ch_valid_i = 4'b0001;
    push(0, mkp(0, 7));
    step();
    ch_valid_i = '0;
    for (int i = 0; i < 3; i++) begin
      chk("t5_hold_valid", 32'(out_valid_o), 32'd0);
      chk("t5_hold_allowin", 32'(ch_allowIn_o), 32'b1110);
      if (i < 2) step();
    end
    arb_hold_i = 1'b0;
    step();
    chk("t5_release_valid", 32'(out_valid_o), 32'd1);
    chk("t5_release_ch", 32'(out_ch_id_o), 32'd0);
    drain("t5");

    // Test 6: reset with output valid and three holding registers valid
    out_allowIn_i = 1'b0;
    for (int k = 0; k < 4; k++) set_ch(k, mkp(k, 5));
    ch_valid_i = 4'hF;
    step();
    ch_valid_i = '0;
    step();
    chk("t6_pre_valid", 32'(out_valid_o), 32'd1);
    chk("t6_pre_allowin", 32'(ch_allowIn_o), 32'b0010);
    rst_i = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(out_valid_o), 32'd0);
    chk("t6_rst_allowin", 32'(ch_allowIn_o), 32'hF);
    chk("t6_rst_busy", 32'(busy_o), 32'd0);
    step();
    rst_i = 1'b0;
    out_allowIn_i = 1'b1;
    set_ch(1, mkp(1, 6));
    set_ch(3, mkp(3, 6));
    ch_valid_i = 4'b1010;
    push(1, mkp(1, 6));
    push(3, mkp(3, 6));
    step();
    ch_valid_i = '0;
    step();
    chk("t6_first_ch", 32'(out_ch_id_o), 32'd1);
    drain("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
